// File: rtl/approx_mul_seq.sv
// approx_mul_seq: sequential 8x8 unsigned multiplier built around a single
// 4x4 sub-multiplier that is stepped over the four nibble products.
// Optional build macro LL_TRUNC_EN drops the low*low nibble pass, giving a
// faster approximate product (LL term treated as zero).
// Parameter FLUSH_ON_ZERO short-circuits a zero operand straight to DONE.
module approx_mul_seq #(
    parameter int unsigned FLUSH_ON_ZERO = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] prod8,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        PP_LL,
        PP_LH,
        PP_HL,
        PP_HH,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] acc;

    logic        accept;
    logic        zero_op;
    logic        acc_add;

    logic [3:0]  mul_x;
    logic [3:0]  mul_y;
    logic [7:0]  pp;
    logic [15:0] pp_shifted;

    assign accept  = in_valid && (state == IDLE);
    assign zero_op = (FLUSH_ON_ZERO != 0) && ((a == '0) || (b == '0));
    assign prod8   = acc;

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        acc_add    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    if (zero_op) begin
                        state_next = DONE;
                    end else begin
`ifdef LL_TRUNC_EN
                        state_next = PP_LH;
`else
                        state_next = PP_LL;
`endif
                    end
                end
            end
            PP_LL: begin
                acc_add    = 1'b1;
                state_next = PP_LH;
            end
            PP_LH: begin
                acc_add    = 1'b1;
                state_next = PP_HL;
            end
            PP_HL: begin
                acc_add    = 1'b1;
                state_next = PP_HH;
            end
            PP_HH: begin
                acc_add    = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Nibble selection for the shared 4x4 multiplier and alignment of its result.
    always_comb begin
        mul_x      = a_q[3:0];
        mul_y      = b_q[3:0];
        pp_shifted = '0;
        case (state)
            PP_LH:   mul_y = b_q[7:4];
            PP_HL:   mul_x = a_q[7:4];
            PP_HH: begin
                mul_x = a_q[7:4];
                mul_y = b_q[7:4];
            end
            default: ;
        endcase
        pp = {4'b0000, mul_x} * {4'b0000, mul_y};
        case (state)
            PP_LL:         pp_shifted = {8'h00, pp};
            PP_LH, PP_HL:  pp_shifted = {4'h0, pp, 4'h0};
            PP_HH:         pp_shifted = {pp, 8'h00};
            default:       pp_shifted = '0;
        endcase
    end

    // Operand capture on accept and 16-bit modulo accumulation per pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            acc <= '0;
        end else if (accept) begin
            a_q <= a;
            b_q <= b;
            acc <= '0;
        end else if (acc_add) begin
            acc <= acc + pp_shifted;
        end
    end

endmodule

// File: tb/tb_approx_mul_seq.sv
// Scoreboard bench for approx_mul_seq: stimulus pushes expected product and
// latency at accept; a negedge monitor checks every presented result.
// Build with +define+LL_TRUNC_EN to check the truncated variant.
module tb_approx_mul_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] prod8;
    logic        busy;

`ifdef LL_TRUNC_EN
    localparam int unsigned LAT = 4;
`else
    localparam int unsigned LAT = 5;
`endif

    typedef struct {
        logic [15:0] prod;
        int unsigned lat;
        int unsigned acc_edge;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_vec;
    int unsigned n_err;
    int unsigned edge_cnt;
    bit          held;
    logic [15:0] hold_val;

    approx_mul_seq #(.FLUSH_ON_ZERO(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod8     (prod8),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Monitor: checks handshake, hold stability, latency and value on pop.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else if (out_valid) begin
            n_vec++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL done_flags: in_ready=%b busy=%b, required 0/1", in_ready, busy);
            end
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_result: prod8=%h with nothing outstanding", prod8);
            end else begin
                if (!held) begin
                    held     = 1'b1;
                    hold_val = prod8;
                    n_vec++;
                    if (edge_cnt - sb[0].acc_edge + 1 != sb[0].lat) begin
                        n_err++;
                        $display("FAIL latency: got %0d edges, required %0d",
                                 edge_cnt - sb[0].acc_edge + 1, sb[0].lat);
                    end
                end else begin
                    n_vec++;
                    if (prod8 !== hold_val) begin
                        n_err++;
                        $display("FAIL hold: prod8=%h, required stable %h", prod8, hold_val);
                    end
                end
                if (out_ready) begin
                    n_vec++;
                    if (prod8 !== sb[0].prod) begin
                        n_err++;
                        $display("FAIL product: prod8=%h, required %h", prod8, sb[0].prod);
                    end
                    void'(sb.pop_front());
                    held = 1'b0;
                end
            end
        end
    end

    task automatic check_idle(input string name);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || prod8 !== 16'h0000) begin
            n_err++;
            $display("FAIL %s: ov=%b ir=%b busy=%b prod8=%h, required 0 1 0 0000",
                     name, out_valid, in_ready, busy, prod8);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        check_idle("reset_state");
    endtask

    // Wait (bounded) for in_ready, then hold in_valid across the accept edge.
    task automatic issue(input logic [7:0] va, input logic [7:0] vb, output bit ok);
        int unsigned tmo;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        tmo      = 0;
        while (!in_ready && tmo < 50) begin
            @(posedge clk);
            #1;
            tmo++;
        end
        ok = in_ready;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready=%b, required 1", in_ready);
            in_valid = 1'b0;
        end
    endtask

    task automatic run_vec(input logic [7:0] va, input logic [7:0] vb,
                           input logic [15:0] exp_exact, input logic [15:0] exp_trunc,
                           input bit flush, input int unsigned stall);
        bit          ok;
        int unsigned cyc;
        int unsigned seen;
        exp_t        e;
        out_ready = (stall == 0);
        issue(va, vb, ok);
        if (!ok) return;
`ifdef LL_TRUNC_EN
        e.prod = exp_trunc;
`else
        e.prod = exp_exact;
`endif
        e.lat      = flush ? 1 : LAT;
        e.acc_edge = edge_cnt + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc      = 0;
        seen     = 0;
        while ((sb.size() != 0 || out_valid) && cyc < 100) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (out_valid) begin
                seen++;
                if (seen > stall) out_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        out_ready = 1'b1;
        n_vec++;
        if (cyc >= 100) begin
            n_err++;
            $display("FAIL result_timeout: outstanding=%0d, required 0", sb.size());
            sb.delete();
        end else if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL back_to_idle: in_ready=%b, required 1", in_ready);
        end
    endtask

    // Abort an operation mid-sequence via reset; nothing may be reported for it.
    task automatic run_abort();
        bit ok;
        out_ready = 1'b1;
        issue(8'h55, 8'h66, ok);
        if (!ok) return;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
`ifndef LL_TRUNC_EN
        @(posedge clk);
        #1;
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        a   = 8'($urandom);
        b   = 8'($urandom);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("mid_seq_reset");
        repeat (6) @(posedge clk);
        #1;
        check_idle("no_stale_result");
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        edge_cnt  = 0;
        held      = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        @(posedge clk);
        #1;
        do_reset();

        //      a      b      exact     trunc     flush stall
        run_vec(8'hFF, 8'hFF, 16'hFE01, 16'hFD20, 1'b0, 0);
        run_vec(8'h12, 8'h34, 16'h03A8, 16'h03A0, 1'b0, 0);
        run_vec(8'h00, 8'h7F, 16'h0000, 16'h0000, 1'b1, 0);
        run_vec(8'h33, 8'h00, 16'h0000, 16'h0000, 1'b1, 0);
        run_vec(8'h9C, 8'h47, 16'h2B44, 16'h2AF0, 1'b0, 3);
        run_vec(8'h10, 8'h10, 16'h0100, 16'h0100, 1'b0, 0);
        run_vec(8'hA5, 8'h5A, 16'h3A02, 16'h39D0, 1'b0, 1);
        run_vec(8'h80, 8'h01, 16'h0080, 16'h0080, 1'b0, 0);

        run_abort();
        run_vec(8'h03, 8'h05, 16'h000F, 16'h0000, 1'b0, 0);
        run_vec(8'h01, 8'hFF, 16'h00FF, 16'h00F0, 1'b0, 2);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
